data_bus: RTL and testbench
===========================

Name: data_bus

Overview:
- Downstream consumer of the single-cycle core's data memory interface: decodes the core's address, write data and write enable.
- Routes each access to on-chip data RAM or to memory-mapped peripheral registers: GPIO, timer/compare, and a byte TX FIFO with valid/ready output.
- Read data is combinational, so loads complete in the core's single cycle; writes commit on the clock edge.

Parameters:
- DATA_WIDTH_P, 32, data/address bus width
- RAM_ADDR_WIDTH_P, 8, log2 of RAM depth in 32-bit words
- GPIO_WIDTH_P, 8, GPIO in/out width (<=32)
- TX_FIFO_DEPTH_P, 4, TX FIFO entries; power of two, >=2

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset (asserted when 0)
- i_mem_addr  input  32  byte address from core
- i_mem_wr_en  input  1  write strobe from core
- i_mem_wr_data  input  32  write data from core
- o_mem_rd_data  output  32  combinational read data to core
- i_gpio  input  GPIO_WIDTH_P  asynchronous GPIO inputs
- o_gpio  output  GPIO_WIDTH_P  GPIO output register
- o_timer_irq  output  1  sticky timer-match flag
- o_tx_data  output  8  FIFO head byte
- o_tx_valid  output  1  FIFO non-empty
- i_tx_ready  input  1  consumer accepts head this cycle

Behaviour:

Address decode
- Word-aligned only; addr[1:0] ignored.
- RAM region: addr[31:16]==0x0000.
  - Index is addr[RAM_ADDR_WIDTH_P+1:2]; higher bits in the region alias.
  - Write on posedge when wr_en.
  - RAM contents are not reset.
- MMIO region: addr[31:8]==0xFFFF00.
  - 0x00 GPIO_OUT, RW.
  - 0x04 GPIO_IN, RO: i_gpio through a 2-flop synchroniser.
  - 0x08 TIMER_COUNT, RW.
  - 0x0C TIMER_CMP, RW.
  - 0x10 STATUS:
    - bit0 match flag, W1C
    - bit1 fifo full
    - bit2 fifo empty
    - bit3 overflow, W1C
    - bits[15:8] fifo count
  - 0x14 TX_DATA, WO: push wr_data[7:0]; reads 0.
  - Unused bits read 0; registers narrower than 32 bits are zero-extended.
- Any other address reads 0; writes to it are ignored.

Side effects
- Reads have NO side effects. The core drives the address every cycle, including non-load instructions.

Reset (reset==0, async)
- o_gpio=0, GPIO synchroniser=0, TIMER_COUNT=0.
- TIMER_CMP=0xFFFFFFFF.
- match flag=0, overflow=0.
- FIFO emptied (o_tx_valid=0, o_tx_data=0).
- Reset mid-transfer drops all queued bytes.

Timer
- COUNT increments by 1 every clock; wraps 0xFFFFFFFF->0.
- A write to COUNT loads it; the write has priority over the increment.
- Match flag sets on the cycle after registered COUNT==CMP.
- Flag set and W1C in the same cycle: set wins.
- o_timer_irq = match flag.

TX FIFO
- Pop when o_tx_valid && i_tx_ready.
- o_tx_data is the head entry; registered storage, combinational head select.
- A push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
- Otherwise the push is dropped and overflow is set.
- Simultaneous push+pop: count unchanged.
- Pointers wrap modulo DEPTH.
- Count width is log2(DEPTH)+1.

Optional Feature:
- Macro: DATA_BUS_TIMER_EN.
- Defined: timer registers, match flag and o_timer_irq operate as above.
- Undefined:
  - No timer logic is built.
  - 0x08/0x0C read 0 and writes are ignored.
  - STATUS bit0 reads 0.
  - o_timer_irq is tied 0.

Test Plan:
- Reset, then write 0x12345678 to 0x00000040 and read it back -> o_mem_rd_data=0x12345678. Read 0x00000040+(4<<RAM_ADDR_WIDTH_P) -> same value (alias).
- Write 0xA5 to 0xFFFF0000 -> o_gpio=0xA5 next cycle. Drive i_gpio=0x3C, read 0xFFFF0004 -> 0x3C after 2 clocks, 0 before.
- Timer (DATA_BUS_TIMER_EN): write CMP=10, COUNT=0 -> o_timer_irq rises the cycle after COUNT==10. Write STATUS=0x1 -> flag clears. Writing 0x1 on the set cycle -> flag stays 1.
- Hold i_tx_ready=0, push 0x11,0x22,0x33,0x44,0x55 to 0xFFFF0014 -> STATUS full=1, count=4, overflow=1. Raise ready -> o_tx_data sequence 0x11,0x22,0x33,0x44, then o_tx_valid=0 and empty=1.
- FIFO full with ready=1, push 0x66 same cycle -> accepted, count stays 4, no overflow.
- Assert reset mid-stream with 3 bytes queued -> o_tx_valid=0, count=0, o_gpio=0 immediately (async). Repeated reads of 0xFFFF0010 -> FIFO and flags unchanged.

Source files
------------

// File: rtl/data_bus.sv
// data_bus: data-side bus decoder for the single-cycle core.
// Routes word accesses to on-chip RAM or to MMIO registers: GPIO, timer/compare and a byte TX FIFO.
// Read data is combinational, so loads finish in the same cycle. Writes commit on the rising edge.
// The optional timer is built only when DATA_BUS_TIMER_EN is defined. Otherwise 0x08/0x0C read as zero
// and o_timer_irq is tied low.
module data_bus #(
    parameter int DATA_WIDTH_P     = 32,
    parameter int RAM_ADDR_WIDTH_P = 8,
    parameter int GPIO_WIDTH_P     = 8,
    parameter int TX_FIFO_DEPTH_P  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH_P-1:0] i_mem_addr,
    input  logic                    i_mem_wr_en,
    input  logic [DATA_WIDTH_P-1:0] i_mem_wr_data,
    output logic [DATA_WIDTH_P-1:0] o_mem_rd_data,
    input  logic [GPIO_WIDTH_P-1:0] i_gpio,
    output logic [GPIO_WIDTH_P-1:0] o_gpio,
    output logic                    o_timer_irq,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready
);
    localparam int RAM_DEPTH_L = 1 << RAM_ADDR_WIDTH_P;
    localparam int PTR_W_L     = $clog2(TX_FIFO_DEPTH_P);
    localparam int CNT_W_L     = PTR_W_L + 1;

    // Address decode. Accesses are word aligned, so bits [1:0] play no part.
    logic                        ram_sel;
    logic                        mmio_sel;
    logic [5:0]                  mmio_off;
    logic [RAM_ADDR_WIDTH_P-1:0] ram_idx;
    logic [1:0]                  unused_addr_lsb;

    assign ram_sel         = (i_mem_addr[DATA_WIDTH_P-1 -: 16] == 16'h0000);
    assign mmio_sel        = (i_mem_addr[DATA_WIDTH_P-1:8] == 24'hFFFF00);
    assign mmio_off        = i_mem_addr[7:2];
    assign ram_idx         = i_mem_addr[RAM_ADDR_WIDTH_P+1:2];
    assign unused_addr_lsb = i_mem_addr[1:0];

    logic wr_gpio, wr_status, push;
    assign wr_gpio   = i_mem_wr_en && mmio_sel && (mmio_off == 6'h00);
    assign wr_status = i_mem_wr_en && mmio_sel && (mmio_off == 6'h04);
    assign push      = i_mem_wr_en && mmio_sel && (mmio_off == 6'h05);

    // Data RAM: write on the clock edge. Contents are deliberately left unreset.
    logic [DATA_WIDTH_P-1:0] ram [RAM_DEPTH_L];
    always_ff @(posedge clk) begin
        if (i_mem_wr_en && ram_sel) ram[ram_idx] <= i_mem_wr_data;
    end

    // GPIO output register and two-flop input synchroniser.
    logic [GPIO_WIDTH_P-1:0] gpio_sync1, gpio_sync2;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_gpio     <= '0;
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
        end else begin
            gpio_sync1 <= i_gpio;
            gpio_sync2 <= gpio_sync1;
            if (wr_gpio) o_gpio <= i_mem_wr_data[GPIO_WIDTH_P-1:0];
        end
    end

    logic match_flag;
`ifdef DATA_BUS_TIMER_EN
    logic                    wr_count, wr_cmp;
    logic [DATA_WIDTH_P-1:0] timer_count, timer_cmp;
    assign wr_count = i_mem_wr_en && mmio_sel && (mmio_off == 6'h02);
    assign wr_cmp   = i_mem_wr_en && mmio_sel && (mmio_off == 6'h03);

    // Free-running timer. A software load wins over the increment, and a match set wins over W1C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_count <= '0;
            timer_cmp   <= '1;
            match_flag  <= 1'b0;
        end else begin
            timer_count <= wr_count ? i_mem_wr_data : timer_count + DATA_WIDTH_P'(1);
            if (wr_cmp) timer_cmp <= i_mem_wr_data;
            if (timer_count == timer_cmp)            match_flag <= 1'b1;
            else if (wr_status && i_mem_wr_data[0])  match_flag <= 1'b0;
        end
    end
`else
    assign match_flag = 1'b0;
`endif
    assign o_timer_irq = match_flag;

    // TX FIFO handshake: the head byte transfers on any cycle where o_tx_valid and i_tx_ready are both high.
    // o_tx_valid is high whenever the FIFO is non-empty and does not depend on i_tx_ready.
    // When the FIFO is full, a push in the same cycle as a pop is still accepted.
    logic [7:0]         fifo_mem [TX_FIFO_DEPTH_P];
    logic [PTR_W_L-1:0] rd_ptr, wr_ptr;
    logic [CNT_W_L-1:0] fifo_count;
    logic               overflow, pop, push_ok, fifo_full, fifo_empty;

    assign fifo_full  = (fifo_count == CNT_W_L'(TX_FIFO_DEPTH_P));
    assign fifo_empty = (fifo_count == '0);
    assign o_tx_valid = !fifo_empty;
    assign pop        = o_tx_valid && i_tx_ready;
    assign push_ok    = push && (!fifo_full || pop);
    assign o_tx_data  = o_tx_valid ? fifo_mem[rd_ptr] : 8'h00;

    // FIFO storage. Only the pointers and count are reset, and the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= i_mem_wr_data[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow. A dropped push wins over the overflow W1C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W_L'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W_L'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W_L'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W_L'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push && !push_ok)                   overflow <= 1'b1;
            else if (wr_status && i_mem_wr_data[3]) overflow <= 1'b0;
        end
    end

    // Combinational read mux. Reads have no side effects.
    always_comb begin
        o_mem_rd_data = '0;
        if (ram_sel) begin
            o_mem_rd_data = ram[ram_idx];
        end else if (mmio_sel) begin
            case (mmio_off)
                6'h00: o_mem_rd_data[GPIO_WIDTH_P-1:0] = o_gpio;
                6'h01: o_mem_rd_data[GPIO_WIDTH_P-1:0] = gpio_sync2;
`ifdef DATA_BUS_TIMER_EN
                6'h02: o_mem_rd_data = timer_count;
                6'h03: o_mem_rd_data = timer_cmp;
`endif
                6'h04: begin
                    o_mem_rd_data[0]           = match_flag;
                    o_mem_rd_data[1]           = fifo_full;
                    o_mem_rd_data[2]           = fifo_empty;
                    o_mem_rd_data[3]           = overflow;
                    o_mem_rd_data[8 +: CNT_W_L] = fifo_count;
                end
                default: o_mem_rd_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus.sv
// Directed bench for data_bus covering RAM, GPIO, timer (when built), the TX FIFO and async reset.
module tb_data_bus;
    localparam logic [31:0] A_GPIO_OUT = 32'hFFFF0000;
    localparam logic [31:0] A_GPIO_IN  = 32'hFFFF0004;
    localparam logic [31:0] A_COUNT    = 32'hFFFF0008;
    localparam logic [31:0] A_CMP      = 32'hFFFF000C;
    localparam logic [31:0] A_STATUS   = 32'hFFFF0010;
    localparam logic [31:0] A_TX       = 32'hFFFF0014;

    logic        clk, reset;
    logic [31:0] i_mem_addr, i_mem_wr_data, o_mem_rd_data;
    logic        i_mem_wr_en;
    logic [7:0]  i_gpio, o_gpio, o_tx_data;
    logic        o_timer_irq, o_tx_valid, i_tx_ready;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          model_count = 0;

    data_bus dut (
        .clk(clk), .reset(reset),
        .i_mem_addr(i_mem_addr), .i_mem_wr_en(i_mem_wr_en),
        .i_mem_wr_data(i_mem_wr_data), .o_mem_rd_data(o_mem_rd_data),
        .i_gpio(i_gpio), .o_gpio(o_gpio), .o_timer_irq(o_timer_irq),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive one write, return at the next negedge after it committed.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        i_mem_addr = addr; i_mem_wr_data = data; i_mem_wr_en = 1'b1;
        @(negedge clk);
        i_mem_wr_en = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        i_mem_addr = addr; i_mem_wr_en = 1'b0;
        #1;
        check(tag, o_mem_rd_data, exp);
    endtask

    // Push one byte to the TX FIFO and update the model (assumes no pop in this cycle).
    task automatic push_byte(input logic [7:0] b);
        if (model_count < 4) begin
            exp_q.push_back(b);
            model_count++;
        end
        wr(A_TX, {24'h0, b});
    endtask

    initial begin
        logic [31:0] rdata [4];
        logic [7:0]  exp_b;
        int          n;

        reset = 1'b0; i_mem_addr = A_STATUS; i_mem_wr_en = 1'b0; i_mem_wr_data = '0;
        i_gpio = 8'h00; i_tx_ready = 1'b0;
        #2;
        check("rst_gpio", {24'h0, o_gpio}, 32'h0);
        check("rst_valid", {31'h0, o_tx_valid}, 32'h0);
        check("rst_txdata", {24'h0, o_tx_data}, 32'h0);
        check("rst_irq", {31'h0, o_timer_irq}, 32'h0);
        check("rst_status", o_mem_rd_data, 32'h4);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        // RAM write/read and aliasing
        wr(32'h0000_0040, 32'h1234_5678);
        rd_check("ram_rd", 32'h0000_0040, 32'h1234_5678);
        rd_check("ram_alias", 32'h0000_0040 + (32'd4 << 8), 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            rdata[i] = $urandom_range(32'h7FFF_FFFF, 0);
            wr(32'h0000_0100 + 32'(i * 4), rdata[i]);
        end
        for (int i = 0; i < 4; i++) rd_check("ram_rand", 32'h0000_0100 + 32'(i * 4), rdata[i]);
        rd_check("ram_keep", 32'h0000_0040, 32'h1234_5678);
        wr(32'h0001_0040, 32'hDEAD_BEEF);
        rd_check("unmapped", 32'h0001_0040, 32'h0);
        rd_check("ram_unhit", 32'h0000_0040, 32'h1234_5678);

        // GPIO
        wr(A_GPIO_OUT, 32'hA5);
        check("gpio_out", {24'h0, o_gpio}, 32'hA5);
        rd_check("gpio_out_rd", A_GPIO_OUT, 32'hA5);
        i_gpio = 8'h3C;
        rd_check("gpio_in_0", A_GPIO_IN, 32'h0);
        @(negedge clk);
        rd_check("gpio_in_1", A_GPIO_IN, 32'h0);
        @(negedge clk);
        rd_check("gpio_in_2", A_GPIO_IN, 32'h3C);

`ifdef DATA_BUS_TIMER_EN
        rd_check("cmp_rst", A_CMP, 32'hFFFF_FFFF);
        wr(A_CMP, 32'd10);
        wr(A_COUNT, 32'd0);
        rd_check("count0", A_COUNT, 32'd0);
        repeat (10) @(negedge clk);
        rd_check("count10", A_COUNT, 32'd10);
        check("irq_pre", {31'h0, o_timer_irq}, 32'h0);
        @(negedge clk);
        check("irq_set", {31'h0, o_timer_irq}, 32'h1);
        wr(A_STATUS, 32'h1);
        check("irq_w1c", {31'h0, o_timer_irq}, 32'h0);
        wr(A_COUNT, 32'd8);
        repeat (2) @(negedge clk);
        wr(A_STATUS, 32'h1);
        check("irq_setwins", {31'h0, o_timer_irq}, 32'h1);
        wr(A_STATUS, 32'h1);
        check("irq_clear2", {31'h0, o_timer_irq}, 32'h0);
`else
        wr(A_COUNT, 32'd5);
        wr(A_CMP, 32'd0);
        rd_check("count_off", A_COUNT, 32'h0);
        rd_check("cmp_off", A_CMP, 32'h0);
        check("irq_off", {31'h0, o_timer_irq}, 32'h0);
`endif

        // FIFO fill with ready low: fifth push overflows
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44); push_byte(8'h55);
        rd_check("status_full", A_STATUS, 32'h40A);
        rd_check("tx_rd0", A_TX, 32'h0);
        i_tx_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 12 && o_tx_valid; k++) begin
            #1;
            exp_b = 8'hXX;
            if (exp_q.size() != 0) exp_b = exp_q.pop_front();
            check("tx_data", {24'h0, o_tx_data}, {24'h0, exp_b});
            n++;
            @(negedge clk);
        end
        i_tx_ready = 1'b0;
        model_count = 0;
        check("tx_npop", n, 32'd4);
        check("tx_valid0", {31'h0, o_tx_valid}, 32'h0);
        rd_check("status_empty", A_STATUS, 32'hC);
        wr(A_STATUS, 32'h8);
        rd_check("status_ovf_clr", A_STATUS, 32'h4);

        // Full FIFO: push with concurrent pop is accepted
        push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
        rd_check("status_full2", A_STATUS, 32'h402);
        i_tx_ready = 1'b1;
        #1;
        exp_b = exp_q.pop_front();
        check("tx_head_a1", {24'h0, o_tx_data}, {24'h0, exp_b});
        exp_q.push_back(8'h66);
        wr(A_TX, 32'h66);
        i_tx_ready = 1'b0;
        rd_check("status_pushpop", A_STATUS, 32'h402);
        i_tx_ready = 1'b1;
        #1;
        exp_b = exp_q.pop_front();
        check("tx_head_a2", {24'h0, o_tx_data}, {24'h0, exp_b});
        @(negedge clk);
        i_tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rd_check("status_noside", A_STATUS, 32'h300);
            check("tx_head_hold", {24'h0, o_tx_data}, {24'h0, exp_q[0]});
            @(negedge clk);
        end

        // Async reset with three bytes queued
        wr(A_GPIO_OUT, 32'h5A);
        check("gpio_5a", {24'h0, o_gpio}, 32'h5A);
        i_mem_addr = A_STATUS;
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", {31'h0, o_tx_valid}, 32'h0);
        check("arst_gpio", {24'h0, o_gpio}, 32'h0);
        check("arst_status", o_mem_rd_data, 32'h4);
        check("arst_txdata", {24'h0, o_tx_data}, 32'h0);
        exp_q.delete();
        model_count = 0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        push_byte(8'h77);
        check("post_valid", {31'h0, o_tx_valid}, 32'h1);
        check("post_data", {24'h0, o_tx_data}, {24'h0, exp_q[0]});
        rd_check("post_status", A_STATUS, 32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so a stuck run still terminates with a summary.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
